// File: rtl/pipe_skid_reg.sv
// Purpose: two-slot elastic pipeline register (main + skid) with valid/ready on both sides.
// Latency: 1 cycle from in_fire to out_valid/out_data; 1 word/cycle sustained with out_ready high.
// Backpressure: in_ready is a flop bit, so one extra word is absorbed into the skid slot after a stall begins.
// Optional: define PIPE_SKID_STATS_EN to add the saturating stall_cnt counter and port.
module pipe_skid_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef PIPE_SKID_STATS_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);

  // State encoding is {out_valid, in_ready}, so both handshake outputs are raw flop bits.
  typedef enum logic [1:0] {
    EMPTY = 2'b01,
    FULL  = 2'b11,
    SKID  = 2'b10
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] main_nxt;
  logic [WIDTH-1:0] skid_q;
  logic [WIDTH-1:0] skid_nxt;
  logic             in_fire;
  logic             out_fire;

  assign in_ready  = state[0];
  assign out_valid = state[1];
  assign out_data  = main_q;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // Next-state and data-slot selection; flush overrides every transition.
  always_comb begin
    state_nxt = state;
    main_nxt  = main_q;
    skid_nxt  = skid_q;
    if (flush) begin
      // Words handshaken this cycle are dropped; data slots are don't-care once EMPTY.
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            state_nxt = FULL;
            main_nxt  = in_data;
          end
        end
        FULL: begin
          if (in_fire && out_fire) begin
            main_nxt = in_data;
          end else if (in_fire) begin
            // Downstream stalled while a new word arrived: park it behind the head word.
            state_nxt = SKID;
            skid_nxt  = in_data;
          end else if (out_fire) begin
            state_nxt = EMPTY;
          end
        end
        SKID: begin
          // in_ready is low here, so only the drain of the head word can happen.
          if (out_fire) begin
            state_nxt = FULL;
            main_nxt  = skid_q;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // State and data registers; reset drops held words without waiting for a clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state  <= state_nxt;
      main_q <= main_nxt;
      skid_q <= skid_nxt;
    end
  end

`ifdef PIPE_SKID_STATS_EN
  logic [15:0] stall_q;

  assign stall_cnt = stall_q;

  // Count cycles where a word is offered but refused; saturate, and only reset clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= 16'd0;
    end else if (out_valid && !out_ready && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end
`endif

endmodule
